seq_alu_gen2: RTL and testbench

//   Parametrised multi-cycle ALU; successor to simple_alu and pin-compatible with its bench

---
 rtl/alu_gen2_pkg.sv | 20 ++
 rtl/seq_alu_gen2_if.sv | 23 ++
 rtl/alu_mul_seq.sv | 69 ++++++
 rtl/seq_alu_gen2.sv | 156 +++++++++++++++
 tb/tb_seq_alu_gen2.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/alu_gen2_pkg.sv
// Shared opcode codes and frame FSM encoding for the gen2 sequential ALU.
package alu_gen2_pkg;

  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_ADD  = 1;
  localparam int unsigned OP_SUB  = 2;
  localparam int unsigned OP_AND  = 3;
  localparam int unsigned OP_OR   = 4;
  localparam int unsigned OP_XOR  = 5;
  localparam int unsigned OP_MUL  = 6;
  localparam int unsigned OP_NOTA = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_MUL  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_alu_gen2_if.sv
// Command/result bus of the gen2 sequential ALU.
interface seq_alu_gen2_if #(
  parameter int unsigned WIDTH = 8
);
  logic             opcode_valid;
  logic             opcode;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             overflow;
  logic             error;
  logic             busy;

  modport master (
    output opcode_valid, opcode, data,
    input  result, done, overflow, error, busy
  );

  modport slave (
    input  opcode_valid, opcode, data,
    output result, done, overflow, error, busy
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH cycles.
// done_c_o/product_c_o flag the final iteration combinationally so the caller can
// register the full product on the same edge that retires the last step.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_c_o,
  output logic [2*WIDTH-1:0] product_c_o
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic               run_q, run_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_next_c;

  // Accumulate the current partial product and step the shifters.
  always_comb begin
    run_d       = run_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    acc_next_c  = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_c_o    = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    product_c_o = acc_next_c;
    if (start_i) begin
      run_d    = 1'b1;
      cnt_d    = '0;
      mcand_d  = (2*WIDTH)'(a_i);
      mplier_d = b_i;
      acc_d    = '0;
    end else if (run_q) begin
      acc_d    = acc_next_c;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (done_c_o) begin
        run_d = 1'b0;
      end
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/seq_alu_gen2.sv
// Multi-cycle unsigned ALU: serial opcode framing, single-cycle datapath for simple
// ops, iterative multiply, registered result/overflow/error/busy with a done pulse.
module seq_alu_gen2
  import alu_gen2_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seq_alu_gen2_if.slave        alu_if
);

  localparam int unsigned CNT_W = $clog2(OPW + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OPW-1:0]     op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d, err_q, err_d, done_q, done_d, busy_q, busy_d;

  logic               illegal_c;
  logic [WIDTH:0]     sum_c;
  logic [WIDTH-1:0]   alu_res_c;
  logic               alu_ovf_c;
  logic               mul_start_c;
  logic               mul_done_c;
  logic [2*WIDTH-1:0] mul_prod_c;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (mul_start_c),
    .a_i         (a_q),
    .b_i         (b_q),
    .done_c_o    (mul_done_c),
    .product_c_o (mul_prod_c)
  );

  // Single-cycle datapath for every opcode except MUL.
  always_comb begin
    illegal_c = (op_q > OPW'(OP_NOTA));
    sum_c     = {1'b0, a_q} + {1'b0, b_q};
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    case (op_q[2:0])
      3'(OP_ADD):  begin alu_res_c = sum_c[WIDTH-1:0]; alu_ovf_c = sum_c[WIDTH]; end
      3'(OP_SUB):  begin alu_res_c = a_q - b_q;        alu_ovf_c = (a_q < b_q);  end
      3'(OP_AND):  alu_res_c = a_q & b_q;
      3'(OP_OR):   alu_res_c = a_q | b_q;
      3'(OP_XOR):  alu_res_c = a_q ^ b_q;
      3'(OP_NOTA): alu_res_c = ~a_q;
      default:     alu_res_c = '0;
    endcase
    if (illegal_c) begin
      alu_res_c = '0;
      alu_ovf_c = 1'b0;
    end
  end

  // Frame FSM: next state, operand/opcode capture and output updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    done_d      = 1'b0;
    mul_start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (alu_if.opcode_valid) begin
          state_d = ST_LOAD;
          op_d    = OPW'(alu_if.opcode);
          a_d     = alu_if.data;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_LOAD: begin
        if (!alu_if.opcode_valid) begin
          state_d = ST_IDLE;
        end else begin
          op_d  = {op_q[OPW-2:0], alu_if.opcode};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            b_d = alu_if.data;
          end
          if (cnt_q == CNT_W'(OPW - 1)) begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (!illegal_c && (op_q[2:0] == 3'(OP_MUL))) begin
          state_d     = ST_MUL;
          mul_start_c = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          result_d = alu_res_c;
          ovf_d    = alu_ovf_c;
          err_d    = illegal_c;
        end
      end
      ST_MUL: begin
        if (mul_done_c) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          result_d = mul_prod_c[WIDTH-1:0];
          ovf_d    = |mul_prod_c[2*WIDTH-1:WIDTH];
          err_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign alu_if.result   = result_q;
  assign alu_if.overflow = ovf_q;
  assign alu_if.error    = err_q;
  assign alu_if.done     = done_q;
  assign alu_if.busy     = busy_q;

endmodule

// File: tb/tb_seq_alu_gen2.sv
// Directed bench for seq_alu_gen2: OPW=3 vector table run back-to-back, plus abort,
// reset-during-multiply and OPW=4 illegal-opcode sequences.
module tb_seq_alu_gen2;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  seq_alu_gen2_if #(.WIDTH(8)) if3 ();
  seq_alu_gen2_if #(.WIDTH(8)) if4 ();

  seq_alu_gen2 #(.WIDTH(8), .OPW(3)) dut3 (.clk(clk), .reset_n(reset_n), .alu_if(if3));
  seq_alu_gen2 #(.WIDTH(8), .OPW(4)) dut4 (.clk(clk), .reset_n(reset_n), .alu_if(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       ovf;
    int         lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel4, input logic v, input logic b, input logic [7:0] d);
    if (sel4) begin
      if4.opcode_valid = v; if4.opcode = b; if4.data = d;
    end else begin
      if3.opcode_valid = v; if3.opcode = b; if3.data = d;
    end
  endtask

  // Starts a frame in the current cycle (called at a negedge) and returns at the
  // negedge of the done cycle, or after a bounded wait.
  task automatic run_op(input bit sel4, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, output int lat, output logic [7:0] res,
                        output logic ovf, output logic err, output bit busy_ok);
    int   opw;
    logic dn, bz;
    opw = sel4 ? 4 : 3;
    lat = -1; res = '0; ovf = 1'b0; err = 1'b0; busy_ok = 1'b1;
    drive(sel4, 1'b1, op[opw-1], a);
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      dn = sel4 ? if4.done : if3.done;
      bz = sel4 ? if4.busy : if3.busy;
      if (bz !== !dn) busy_ok = 1'b0;
      if (dn) begin
        lat = c;
        res = sel4 ? if4.result   : if3.result;
        ovf = sel4 ? if4.overflow : if3.overflow;
        err = sel4 ? if4.error    : if3.error;
      end else if (c < opw) begin
        drive(sel4, 1'b1, op[opw-1-c], (c == 1) ? b : 8'h00);
      end else begin
        drive(sel4, 1'b0, 1'b0, 8'h00);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] res;
    logic       ovf, err;
    bit         bok;
    int         dn;
    logic [7:0] prev;

    n_tests = 0;
    n_fail  = 0;
    vecs[0]  = '{3'd1, 8'hF0, 8'h20, 8'h10, 1'b1, 4};   // ADD carry
    vecs[1]  = '{3'd0, 8'h12, 8'h34, 8'h00, 1'b0, 4};   // NOP clears overflow
    vecs[2]  = '{3'd2, 8'h05, 8'h07, 8'hFE, 1'b1, 4};   // SUB borrow
    vecs[3]  = '{3'd5, 8'hAA, 8'hFF, 8'h55, 1'b0, 4};   // XOR back-to-back
    vecs[4]  = '{3'd6, 8'h10, 8'h11, 8'h10, 1'b1, 12};  // MUL high half set
    vecs[5]  = '{3'd6, 8'h0F, 8'h0F, 8'hE1, 1'b0, 12};  // MUL fits
    vecs[6]  = '{3'd3, 8'hC3, 8'h5A, 8'h42, 1'b0, 4};   // AND
    vecs[7]  = '{3'd4, 8'hC3, 8'h5A, 8'hDB, 1'b0, 4};   // OR
    vecs[8]  = '{3'd7, 8'h3C, 8'h99, 8'hC3, 1'b0, 4};   // NOT A
    vecs[9]  = '{3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 4};   // ADD wrap to zero
    vecs[10] = '{3'd2, 8'h07, 8'h05, 8'h02, 1'b0, 4};   // SUB no borrow
    vecs[11] = '{3'd2, 8'h05, 8'h05, 8'h00, 1'b0, 4};   // SUB equal
    vecs[12] = '{3'd6, 8'hFF, 8'hFF, 8'h01, 1'b1, 12};  // MUL max
    vecs[13] = '{3'd1, 8'h7F, 8'h01, 8'h80, 1'b0, 4};   // ADD no carry

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_result", 32'(if3.result), 32'h0);
    check("rst_done", 32'(if3.done), 32'h0);
    check("rst_ovf", 32'(if3.overflow), 32'h0);
    check("rst_err", 32'(if3.error), 32'h0);
    check("rst_busy", 32'(if3.busy), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table vectors, each starting in the done cycle of the previous one.
    for (int i = 0; i < NV; i++) begin
      run_op(1'b0, {1'b0, vecs[i].op}, vecs[i].a, vecs[i].b, lat, res, ovf, err, bok);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_result", i), 32'(res), 32'(vecs[i].res));
      check($sformatf("v%0d_overflow", i), 32'(ovf), 32'(vecs[i].ovf));
      check($sformatf("v%0d_error", i), 32'(err), 32'h0);
      check($sformatf("v%0d_busy", i), 32'(bok), 32'h1);
    end

    // Abort: opcode_valid drops after two frame cycles.
    prev = if3.result;
    drive(1'b0, 1'b1, 1'b0, 8'h11);
    @(negedge clk);
    check("abort_busy_c1", 32'(if3.busy), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 8'h22);
    @(negedge clk);
    check("abort_busy_c2", 32'(if3.busy), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("abort_busy_c3", 32'(if3.busy), 32'h0);
    dn = 0;
    repeat (20) begin
      if (if3.done) dn++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(dn), 32'h0);
    check("abort_result_held", 32'(if3.result), 32'(prev));
    run_op(1'b0, 4'd1, 8'h01, 8'h01, lat, res, ovf, err, bok);
    check("post_abort_latency", 32'(lat), 32'd4);
    check("post_abort_result", 32'(res), 32'h02);

    // Reset asserted while the multiplier is iterating.
    drive(1'b0, 1'b1, 1'b1, 8'h10);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 8'h11);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check("mul_busy_before_rst", 32'(if3.busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("rstmul_result", 32'(if3.result), 32'h0);
    check("rstmul_done", 32'(if3.done), 32'h0);
    check("rstmul_ovf", 32'(if3.overflow), 32'h0);
    check("rstmul_err", 32'(if3.error), 32'h0);
    check("rstmul_busy", 32'(if3.busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (if3.done) dn++;
    end
    check("rstmul_no_done", 32'(dn), 32'h0);

    // OPW=4 instance: legal op, illegal code 1000, then a legal op clears error.
    run_op(1'b1, 4'b0001, 8'h33, 8'h44, lat, res, ovf, err, bok);
    check("w4_add_latency", 32'(lat), 32'd5);
    check("w4_add_result", 32'(res), 32'h77);
    check("w4_add_error", 32'(err), 32'h0);
    run_op(1'b1, 4'b1000, 8'h12, 8'h34, lat, res, ovf, err, bok);
    check("w4_ill_latency", 32'(lat), 32'd5);
    check("w4_ill_result", 32'(res), 32'h00);
    check("w4_ill_error", 32'(err), 32'h1);
    check("w4_ill_ovf", 32'(ovf), 32'h0);
    check("w4_ill_busy", 32'(bok), 32'h1);
    run_op(1'b1, 4'b0001, 8'hFF, 8'h02, lat, res, ovf, err, bok);
    check("w4_clr_result", 32'(res), 32'h01);
    check("w4_clr_ovf", 32'(ovf), 32'h1);
    check("w4_clr_error", 32'(err), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
